// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transaction arbiter.
// Pure declarations: no logic, no latency, no flow control.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int NREQ_DEF           = 4;
    localparam int SPI_W_DEF          = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set req bit at or after rr_ptr, wrapping.
// Latency: combinational. Backpressure: none (pure function of inputs).
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    always_comb begin
        idx = '0;
        any = 1'b0;
        sum = '0;
        pos = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            pos = sum[IW-1:0];
            if (!any && req[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master among NREQ requesters, one transaction per grant; optional watchdog via SPI_ARB_TIMEOUT_EN.
// Latency: spi_start 1 cycle after req seen in IDLE; response 1 cycle after the done rising edge.
// Backpressure: req is a level held until granted; req/req_data are ignored outside IDLE.
module spi_txn_arbiter
    import spi_pkg::*;
#(
    parameter int NREQ           = NREQ_DEF,
    parameter int W              = SPI_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              spi_start,
    output logic [W-1:0]      spi_data_in,
    input  logic [W-1:0]      spi_data_out,
    input  logic              spi_done,
    output logic              busy
);

    localparam int IW = $clog2(NREQ);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]  tx_q, tx_d;
    logic [W-1:0]  rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          done_q;
    logic          done_rise;
    logic          wdog_expired;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // A done level already high on WAIT entry has done_q=1, so it is not an edge.
    assign done_rise = spi_done & ~done_q;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d = wdog_q;
        if (state_q == ST_START) begin
            wdog_d = '0;
        end else if (state_q == ST_WAIT) begin
            wdog_d = wdog_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wdog_expired = (state_q == ST_WAIT) && (wdog_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tx_d       = tx_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    idx_d   = pick_idx;
                    tx_d    = req_data[int'(pick_idx)*W +: W];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done edge beats a simultaneous watchdog expiry.
                if (done_rise) begin
                    rsp_data_d = spi_data_out;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (wdog_expired) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tx_q       <= '0;
            rr_ptr_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_q       <= tx_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            done_q     <= spi_done;
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        if (state_q != ST_IDLE) begin
            gnt[idx_q] = 1'b1;
        end
        if (state_q == ST_RESP) begin
            rsp_valid[idx_q] = 1'b1;
        end
    end

    assign spi_start   = (state_q == ST_START);
    assign busy        = (state_q != ST_IDLE);
    assign spi_data_in = tx_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized bench for spi_txn_arbiter with a behavioural spi_master model and a transaction-level reference.
module tb_spi_txn_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int TO   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              spi_start;
    logic [W-1:0]      spi_data_in;
    logic [W-1:0]      spi_data_out;
    logic              spi_done;
    logic              busy;

    always #5 clk = ~clk;

    spi_txn_arbiter #(
        .NREQ           (NREQ),
        .W              (W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .spi_start    (spi_start),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_done     (spi_done),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin state: pointer just past the last served requester.
    int model_ptr;

    function automatic int exp_winner(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // spi_master model: answers tx ^ mask after m_delay cycles, as a pulse or a held level.
    int         m_delay;
    bit         m_level;
    bit         m_hang;
    logic [3:0] m_mask;

    initial begin
        logic [3:0] stx;
        logic [3:0] smk;
        int         dl;
        bit         lv;
        spi_done     = 1'b0;
        spi_data_out = '0;
        forever begin
            @(negedge clk);
            if (spi_start && m_hang) begin
                spi_done = 1'b0;
            end else if (spi_start) begin
                stx = spi_data_in;
                smk = m_mask;
                dl  = m_delay;
                lv  = m_level;
                if (!lv) spi_done = 1'b0;
                for (int k = 1; k <= dl; k++) begin
                    @(negedge clk);
                    if (lv && k == 3) spi_done = 1'b0;
                end
                spi_data_out = stx ^ smk;
                spi_done     = 1'b1;
                if (!lv) begin
                    @(negedge clk);
                    spi_done = 1'b0;
                end
            end
        end
    end

    // mode: 0 hold req, 1 winner withdraws req after grant, 2 scramble req/req_data while busy.
    task automatic do_txn(input logic [3:0] r, input logic [15:0] d, input int delay,
                          input bit lvl, input int mode, input bit hang, input logic [3:0] mask);
        int         w;
        int         lat_exp;
        int         lat_obs;
        bit         got;
        logic [3:0] tx;
        logic [3:0] exp_rx;
        w       = exp_winner(r, model_ptr);
        tx      = d[w*4 +: 4];
        exp_rx  = hang ? 4'h0 : (tx ^ mask);
        lat_exp = hang ? TO + 1 : delay + 1;
        m_delay = delay;
        m_level = lvl;
        m_hang  = hang;
        m_mask  = mask;
        req      = r;
        req_data = d;
        @(negedge clk);
        check_val("start_pulse", spi_start, 1);
        check_val("gnt_start", gnt, 32'(1 << w));
        check_val("data_in", spi_data_in, tx);
        check_val("busy_start", busy, 1);
        got     = 1'b0;
        lat_obs = 0;
        for (int c = 1; c <= 300 && !got; c++) begin
            if (mode == 1 && c == 2) req = r & ~(4'b0001 << w);
            if (mode == 2) begin
                req      = 4'($urandom);
                req_data = 16'($urandom);
            end
            @(negedge clk);
            lat_obs = c;
            if (rsp_valid != '0) begin
                got = 1'b1;
            end else begin
                check_val("hold", {spi_start, gnt, spi_data_in}, {1'b0, 4'(1 << w), tx});
            end
        end
        check_val("rsp_seen", got, 1);
        check_val("latency", lat_obs, lat_exp);
        check_val("rsp_valid", rsp_valid, 32'(1 << w));
        check_val("rsp_data", rsp_data, exp_rx);
        check_val("rsp_err", rsp_err, hang);
        check_val("gnt_resp", gnt, 32'(1 << w));
        req       = '0;
        model_ptr = (w + 1) % NREQ;
        @(negedge clk);
        check_val("idle_after", {busy, gnt, rsp_valid, spi_start}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int         pulses;
        logic [3:0] r;
        bit         lv;
        int         dl;
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        m_delay   = 1;
        m_level   = 1'b0;
        m_hang    = 1'b0;
        m_mask    = '0;
        model_ptr = 0;
        repeat (3) @(negedge clk);
        check_val("reset_outs", {spi_start, gnt, rsp_valid, busy, rsp_err, rsp_data, spi_data_in}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_post_reset", {busy, gnt, spi_start}, 0);

        // Single request with loopback, done 20 cycles after start.
        do_txn(4'b0100, 16'h0A00, 20, 1'b0, 0, 1'b0, 4'h0);
        do_txn(4'b1000, 16'h5000, 3, 1'b0, 0, 1'b0, 4'h3);

        // Fairness: all requesting, distinct words, expect 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, 16'h4321, 2 + i, 1'b0, 0, 1'b0, 4'h0);
        end

        // Level done held between transactions.
        for (int i = 0; i < 3; i++) begin
            do_txn(4'($urandom_range(1, 15)), 16'($urandom), 6 + 2 * i, 1'b1, 0, 1'b0, 4'($urandom));
        end

        // Withdrawn request still gets its response; then scrambled inputs while busy.
        do_txn(4'b0100, 16'($urandom), 7, 1'b0, 1, 1'b0, 4'($urandom));
        do_txn(4'b1010, 16'($urandom), 9, 1'b0, 2, 1'b0, 4'($urandom));

        // Reset during WAIT.
        req      = 4'b0010;
        req_data = 16'($urandom);
        m_delay  = 30;
        m_level  = 1'b0;
        m_hang   = 1'b0;
        @(negedge clk);
        check_val("rst_txn_start", {spi_start, gnt}, {1'b1, 4'b0010});
        req = '0;
        repeat (5) @(negedge clk);
        check_val("rst_txn_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("mid_reset_outs", {spi_start, gnt, rsp_valid, busy, rsp_err, rsp_data, spi_data_in}, 0);
        rst_n     = 1'b1;
        model_ptr = 0;
        pulses    = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) pulses++;
        end
        check_val("no_rsp_after_reset", pulses, 0);
        do_txn(4'b1111, 16'hCBA9, 4, 1'b0, 0, 1'b0, 4'($urandom));

        // Wrap from pointer 1 to requester 0; done lands on the watchdog expiry cycle.
        do_txn(4'b0001, 16'($urandom), TO, 1'b0, 0, 1'b0, 4'($urandom));

`ifdef SPI_ARB_TIMEOUT_EN
        do_txn(4'b0010, 16'($urandom), 1, 1'b0, 0, 1'b1, 4'h0);
`else
        do_txn(4'b0010, 16'($urandom), 3 * TO, 1'b0, 0, 1'b0, 4'($urandom));
`endif

        for (int i = 0; i < 24; i++) begin
            r  = 4'($urandom_range(1, 15));
            lv = 1'($urandom_range(0, 1));
            dl = lv ? $urandom_range(5, 14) : $urandom_range(1, 14);
            do_txn(r, 16'($urandom), dl, lv, $urandom_range(0, 2), 1'b0, 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
